data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory slave that answers the CPU's load/store requests over a valid/ready request channel and a valid/ready response channel.
- It is the memory-side end of the CPU's data interface: address, write data, write enable and transfer size in; read data out.
- It replaces the single-cycle datamem so the CPU can be tested against realistic memory latency and error reporting.
- Storage is byte-addressed and little-endian.

Parameters:
- DEPTH_BYTES, 1024, storage size in bytes; must be a power of two and at least 8.
- LATENCY, 2, clock cycles from request acceptance to resp_valid; legal range 1 to 15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- address  input  64  byte address.
- write_data  input  64  store data; low xfer_size bytes are used.
- xfer_size  input  4  transfer size in bytes; legal values 1, 2, 4, 8.
- resp_valid  output  1  response present.
- resp_ready  input  1  CPU accepts the response.
- read_data  output  64  load data, zero-extended; 0 for stores and errors.
- err  output  1  response is an error; valid only while resp_valid=1.

Behaviour:
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: latency counter running.
  - RESP: resp_valid=1, holding the response.
- Reset (asynchronous, any state): state=IDLE, req_ready=1, resp_valid=0, read_data=0, err=0, counter=0. Memory contents are not cleared; a store still in WAIT is discarded.
- Acceptance: a request is accepted on the rising edge where req_valid=1 and req_ready=1. On that edge the responder:
  - captures req_write, address, write_data and xfer_size;
  - sets counter=LATENCY-1 and enters WAIT.
- Inputs are don't-care when no request is being accepted.
- WAIT: req_ready=0. The counter decrements each cycle. On the edge where counter==0 the access is performed and the FSM enters RESP. resp_valid therefore rises exactly LATENCY cycles after the acceptance edge.
- Access rules, evaluated on the captured request:
  - Error condition: xfer_size not in {1,2,4,8}, OR address not a multiple of xfer_size, OR address+xfer_size > DEPTH_BYTES (64-bit compare, no wrap).
  - Error response: err=1, read_data=0, no memory write.
  - Load: byte i of read_data = mem[address+i] for i < xfer_size; upper bytes are 0.
  - Store: mem[address+i] = write_data byte i for i < xfer_size; read_data=0; err=0.
- RESP: resp_valid, read_data and err are held stable until resp_ready=1 is sampled on a rising edge.
  - On that edge the FSM returns to IDLE and resp_valid drops.
  - read_data and err keep their last values but are meaningless while resp_valid=0.
- No overlap: only one request is outstanding at a time. req_ready is 0 throughout WAIT and RESP.
- Back-to-back: the earliest next acceptance is the cycle after the response handshake, so peak throughput is one access per LATENCY+2 cycles.
- Read-after-write: a load accepted after a store's response sees the stored data.
- resp_ready held high in advance: the handshake completes on the first RESP cycle, so resp_valid is high for exactly one cycle.
- X-safety: x or z on inputs while idle with req_valid=0 must not change state.

Test Plan:
- Reset, then store: req_write=1, address=0x10, write_data=0x1122334455667788, xfer_size=8 -> req_ready low next cycle; resp_valid high exactly 2 cycles after acceptance with err=0; then load of the same address returns 0x1122334455667788.
- Sub-word loads after that store:
  - xfer_size=1 at 0x10 -> read_data=0x88.
  - xfer_size=2 at 0x12 -> read_data=0x5566.
  - xfer_size=4 at 0x14 -> read_data=0x11223344.
- Error cases, each giving err=1 and read_data=0:
  - xfer_size=4 at 0x12 (misaligned);
  - xfer_size=3 (illegal size);
  - xfer_size=8 at DEPTH_BYTES-4 (out of range).
  A follow-up load at 0x10 still returns the original data, proving no write occurred.
- Response backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, read_data and err are stable and req_ready=0 throughout; raise resp_ready -> IDLE on the next edge and a new request is accepted the following cycle.
- Reset mid-operation: assert rst asynchronously during WAIT of a store of 0xDEADBEEF to 0x20 -> outputs return to reset values immediately; a subsequent load at 0x20 returns the pre-store contents.
- Latency sweep: with LATENCY=1 and LATENCY=15, resp_valid rises exactly 1 and 15 cycles after acceptance respectively, with resp_ready held high.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressed little-endian data memory slave with valid/ready
// request and response channels, fixed access latency and error reporting.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    input  logic [3:0]  xfer_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] read_data,
    output logic        err
);
    localparam int AW        = $clog2(DEPTH_BYTES);
    localparam int NUM_LANES = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
    } req_t;

    state_t state, state_nxt;
    req_t   req_q;
    logic [3:0] cnt;
    logic [7:0] mem [DEPTH_BYTES];

    logic                            access;
    logic                            size_ok;
    logic                            bad;
    logic [64:0]                     end_addr;
    logic [AW-1:0]                   base;
    logic [NUM_LANES-1:0]            lane_en;
    logic [NUM_LANES-1:0][7:0]       rd_lanes;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign access     = (state == WAIT) && (cnt == 4'd0);

    // Range check is done in 65 bits so addresses near 2^64 cannot wrap back in.
    always_comb begin
        size_ok  = (req_q.size == 4'd1) || (req_q.size == 4'd2) ||
                   (req_q.size == 4'd4) || (req_q.size == 4'd8);
        end_addr = {1'b0, req_q.addr} + 65'(req_q.size);
        bad      = !size_ok ||
                   ((req_q.addr[3:0] & (req_q.size - 4'd1)) != 4'd0) ||
                   (end_addr > 65'(DEPTH_BYTES));
    end

    assign base = req_q.addr[AW-1:0];

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign lane_en[i]  = !bad && (4'(i) < req_q.size);
            assign rd_lanes[i] = (lane_en[i] && !req_q.write) ? mem[base + AW'(i)] : 8'h00;
        end
    endgenerate

    // Storage is deliberately outside the reset domain: contents survive rst.
    always_ff @(posedge clk) begin
        if (access && req_q.write) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_en[i]) mem[base + AW'(i)] <= req_q.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)  state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            req_q     <= '0;
            read_data <= 64'd0;
            err       <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                req_q <= '{write: req_write, addr: address, wdata: write_data, size: xfer_size};
                cnt   <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err       <= bad;
                read_data <= rd_lanes;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: three responders (LATENCY 2, 1, 15) checked
// against a byte-array reference model of the memory and response rules.
module tb_data_mem_responder;
    localparam int DEPTH = 1024;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NDUT-1:0]       req_valid, req_ready, req_write, resp_valid, resp_ready, err;
    logic [NDUT-1:0][63:0] address, write_data, read_data;
    logic [NDUT-1:0][3:0]  xfer_size;

    logic [7:0] mdl [NDUT][DEPTH];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
            data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
                .clk(clk), .rst(rst),
                .req_valid(req_valid[g]), .req_ready(req_ready[g]),
                .req_write(req_write[g]), .address(address[g]),
                .write_data(write_data[g]), .xfer_size(xfer_size[g]),
                .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
                .read_data(read_data[g]), .err(err[g])
            );
        end
    endgenerate

    function automatic int exp_lat(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: a response is an error unless size is 1/2/4/8, address is a
    // multiple of size and the whole access fits below DEPTH.
    task automatic model(input int k, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                         input logic [3:0] sz, output logic [63:0] rd, output logic e);
        int n;
        n  = int'(sz);
        rd = 64'd0;
        e  = 1'b0;
        if (!(n == 1 || n == 2 || n == 4 || n == 8)) e = 1'b1;
        else if (a % 64'(n) != 64'd0) e = 1'b1;
        else if ({1'b0, a} + 65'(n) > 65'(DEPTH)) e = 1'b1;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (wr) mdl[k][int'(a) + i] = wd[8*i +: 8];
                else    rd[8*i +: 8] = mdl[k][int'(a) + i];
            end
        end
    endtask

    // Inputs change on negedge, outputs sampled on negedge; hold = cycles of
    // resp_ready=0 in RESP (0 means resp_ready is already high when RESP starts).
    task automatic xact(input int k, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [3:0] sz, input int hold,
                        output logic [63:0] rd, output logic e, output int lat);
        int w;
        w = 0;
        while (!req_ready[k] && w < 50) begin
            @(posedge clk); @(negedge clk); w++;
        end
        if (w >= 50) chk("req_ready_timeout", {63'd0, req_ready[k]}, 64'd1);
        req_valid[k]  = 1'b1;
        req_write[k]  = wr;
        address[k]    = a;
        write_data[k] = wd;
        xfer_size[k]  = sz;
        resp_ready[k] = (hold == 0);
        @(posedge clk); @(negedge clk);
        req_valid[k]  = 1'b0;
        address[k]    = 'x;
        write_data[k] = 'x;
        xfer_size[k]  = 'x;
        req_write[k]  = 'x;
        chk("req_ready_low_after_accept", {63'd0, req_ready[k]}, 64'd0);
        lat = 0;
        while (!resp_valid[k] && lat < 40) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        if (lat >= 40) chk("resp_timeout", {63'd0, resp_valid[k]}, 64'd1);
        rd = read_data[k];
        e  = err[k];
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", {63'd0, resp_valid[k]}, 64'd1);
            chk("hold_data",  read_data[k], rd);
            chk("hold_err",   {63'd0, err[k]}, {63'd0, e});
            chk("hold_req_ready", {63'd0, req_ready[k]}, 64'd0);
        end
        resp_ready[k] = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready[k] = 1'b0;
        chk("resp_valid_drop", {63'd0, resp_valid[k]}, 64'd0);
        chk("idle_req_ready",  {63'd0, req_ready[k]}, 64'd1);
    endtask

    task automatic run(input int k, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                       input logic [3:0] sz, input int hold, output logic [63:0] rd);
        logic [63:0] erd;
        logic        ee, e;
        int          lat;
        model(k, wr, a, wd, sz, erd, ee);
        xact(k, wr, a, wd, sz, hold, rd, e, lat);
        chk("read_data", rd, erd);
        chk("err", {63'd0, e}, {63'd0, ee});
        chk("latency", 64'(lat), 64'(exp_lat(k)));
    endtask

    logic [63:0] rd;
    logic [3:0]  sz;
    logic [63:0] a;

    initial begin
        req_valid  = '0;
        req_write  = '0;
        resp_ready = '0;
        address    = '0;
        write_data = '0;
        xfer_size  = '0;
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < DEPTH; i++) mdl[k][i] = 8'h00;
        #2;
        chk("rst_req_ready",  {61'd0, req_ready},  {61'd0, 3'b111});
        chk("rst_resp_valid", {61'd0, resp_valid}, 64'd0);
        chk("rst_err",        {61'd0, err},        64'd0);
        chk("rst_read_data",  read_data[0], 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Initialise all of instance 0's storage so every later load is defined.
        for (int i = 0; i < DEPTH; i += 8)
            run(0, 1'b1, 64'(i), {$urandom, $urandom}, 4'd8, 0, rd);

        run(0, 1'b1, 64'h10, 64'h1122334455667788, 4'd8, 0, rd);
        chk("store_rd_zero", rd, 64'd0);
        run(0, 1'b0, 64'h10, 64'd0, 4'd8, 0, rd);
        chk("load8_const", rd, 64'h1122334455667788);
        run(0, 1'b0, 64'h10, 64'd0, 4'd1, 0, rd);
        chk("load1_const", rd, 64'h88);
        run(0, 1'b0, 64'h12, 64'd0, 4'd2, 0, rd);
        chk("load2_const", rd, 64'h5566);
        run(0, 1'b0, 64'h14, 64'd0, 4'd4, 0, rd);
        chk("load4_const", rd, 64'h11223344);

        run(0, 1'b0, 64'h12, 64'd0, 4'd4, 0, rd);
        run(0, 1'b0, 64'h10, 64'd0, 4'd3, 0, rd);
        run(0, 1'b0, 64'(DEPTH - 4), 64'd0, 4'd8, 0, rd);
        run(0, 1'b1, 64'h12, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 0, rd);
        run(0, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd3, 0, rd);
        run(0, 1'b1, 64'(DEPTH - 4), 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 0, rd);
        run(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 0, rd);
        run(0, 1'b0, 64'h10, 64'd0, 4'd8, 0, rd);
        chk("no_write_on_err", rd, 64'h1122334455667788);
        run(0, 1'b0, 64'(DEPTH - 8), 64'd0, 4'd8, 0, rd);
        run(0, 1'b0, 64'(DEPTH - 1), 64'd0, 4'd1, 0, rd);
        run(0, 1'b0, 64'(DEPTH - 1), 64'd0, 4'd2, 0, rd);
        run(0, 1'b0, 64'h10, 64'd0, 4'd0, 0, rd);

        run(0, 1'b0, 64'h10, 64'd0, 4'd8, 5, rd);
        run(0, 1'b0, 64'h14, 64'd0, 4'd4, 0, rd);

        // Asynchronous reset during WAIT of a store must drop the store.
        req_valid[0] = 1'b1; req_write[0] = 1'b1; address[0] = 64'h20;
        write_data[0] = 64'hDEADBEEF; xfer_size[0] = 4'd4; resp_ready[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        req_valid[0] = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_req_ready",  {63'd0, req_ready[0]},  64'd1);
        chk("mid_rst_resp_valid", {63'd0, resp_valid[0]}, 64'd0);
        chk("mid_rst_read_data",  read_data[0], 64'd0);
        chk("mid_rst_err",        {63'd0, err[0]}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(0, 1'b0, 64'h20, 64'd0, 4'd4, 0, rd);

        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 9))
                0: sz = 4'($urandom_range(0, 15));
                default: sz = 4'(1 << $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 9))
                0: a = 64'($urandom_range(0, DEPTH - 1));
                1: a = 64'(DEPTH - $urandom_range(0, 16));
                2: a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, DEPTH - 1)) & ~64'(sz == 4'd0 ? 4'd0 : sz - 4'd1);
            endcase
            run(0, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz, $urandom_range(0, 3), rd);
        end

        for (int k = 1; k < NDUT; k++) begin
            run(k, 1'b1, 64'h40, 64'h0123_4567_89AB_CDEF, 4'd8, 0, rd);
            run(k, 1'b0, 64'h40, 64'd0, 4'd8, 0, rd);
            run(k, 1'b0, 64'h44, 64'd0, 4'd2, 1, rd);
            run(k, 1'b0, 64'h41, 64'd0, 4'd2, 0, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
